// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// -------------
// Program-counter sequencer for the simplemips fetch stage. Owns the PC,
// issues instruction-memory requests, applies branch redirects and stalls,
// and raises a sticky error when the memory never answers.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   stall        in   1 = do not issue a new fetch
//   branch_flag  in   1 = redirect PC to branch_addr
//   branch_addr  in   redirect target (bits [1:0] forced to 00)
//   imem_req     out  fetch request
//   imem_addr    out  fetch address (always equal to pc)
//   imem_ack     in   one-cycle acknowledge, imem_rdata valid with it
//   imem_rdata   in   fetched instruction
//   inst_valid   out  one-cycle pulse per delivered instruction
//   inst         out  delivered instruction, held until the next delivery
//   inst_pc      out  address of inst
//   pc           out  current PC register
//   fetch_err    out  sticky timeout flag
//   dbg_state    out  current FSM state (observation only)
//
// Handshake: imem_req rises with imem_addr valid and both stay stable until
// the cycle in which imem_ack is high; that cycle completes the transfer and
// imem_rdata is taken in the same cycle. A request is never withdrawn once
// raised, except by reset or the timeout.

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc,
    output logic        fetch_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    // The error edge is the one at which the count would reach MAX_WAIT,
    // so imem_req is high for exactly MAX_WAIT unanswered cycles.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pend_q, pend_d;
    logic [31:0]       pend_addr_q, pend_addr_d;

    logic [31:0] target;
    logic [1:0]  unused_addr_bits;

    assign target           = {branch_addr[31:2], 2'b00};
    assign unused_addr_bits = branch_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = 1'b0;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        err_d       = err_q;
        wait_d      = wait_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;

        case (state_q)
            S_IDLE, S_HOLD: begin
                wait_d = '0;
                if (branch_flag) begin
                    pc_d = target;
                end
                state_d = stall ? S_HOLD : S_REQ;
            end

            S_REQ: begin
                if (imem_ack) begin
                    // A same-cycle branch beats a latched one; either way
                    // the returning instruction is from the wrong path.
                    if (branch_flag) begin
                        pc_d = target;
                    end else if (pend_q) begin
                        pc_d = pend_addr_q;
                    end else begin
                        valid_d   = 1'b1;
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + 32'(PC_STEP);
                    end
                    pend_d  = 1'b0;
                    wait_d  = '0;
                    state_d = stall ? S_HOLD : S_REQ;
                end else begin
                    // Request stays in flight; remember the latest target.
                    if (branch_flag) begin
                        pend_d      = 1'b1;
                        pend_addr_d = target;
                    end
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end

            S_ERR: begin
                err_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d = (state_d == S_REQ);
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;
    logic        fetch_err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4),
        .MAX_WAIT(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .branch_flag(branch_flag),
        .branch_addr(branch_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc         (pc),
        .fetch_err  (fetch_err),
        .dbg_state  (dbg_state)
    );

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- reference model ----------------
    // Tracks the controller as a mode word plus the architectural values,
    // updated once per rising edge from the inputs seen at that edge.
    string       m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    logic        m_err;
    int          m_unanswered;
    logic        m_pend;
    logic [31:0] m_pend_addr;

    task automatic model_reset();
        m_mode       = "idle";
        m_pc         = 32'h0;
        m_valid      = 1'b0;
        m_inst       = 32'h0;
        m_inst_pc    = 32'h0;
        m_err        = 1'b0;
        m_unanswered = 0;
        m_pend       = 1'b0;
        m_pend_addr  = 32'h0;
    endtask

    task automatic model_step(input logic s, input logic bf, input logic [31:0] ba,
                              input logic ak, input logic [31:0] rd);
        logic [31:0] tgt;
        tgt     = ba & 32'hFFFF_FFFC;
        m_valid = 1'b0;
        if (m_mode == "idle" || m_mode == "hold") begin
            if (bf) m_pc = tgt;
            m_mode = s ? "hold" : "req";
        end else if (m_mode == "req") begin
            if (ak) begin
                if (bf) m_pc = tgt;
                else if (m_pend) m_pc = m_pend_addr;
                else begin
                    m_valid   = 1'b1;
                    m_inst    = rd;
                    m_inst_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
                m_pend       = 1'b0;
                m_unanswered = 0;
                m_mode       = s ? "hold" : "req";
            end else begin
                if (bf) begin
                    m_pend      = 1'b1;
                    m_pend_addr = tgt;
                end
                m_unanswered++;
                if (m_unanswered == 15) begin
                    m_mode = "err";
                    m_err  = 1'b1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_req"},   32'(imem_req),   32'(m_mode == "req"));
        chk({tag, ".imem_addr"},  imem_addr,       m_pc);
        chk({tag, ".pc"},         pc,              m_pc);
        chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(m_valid));
        chk({tag, ".inst"},       inst,            m_inst);
        chk({tag, ".inst_pc"},    inst_pc,         m_inst_pc);
        chk({tag, ".fetch_err"},  32'(fetch_err),  32'(m_err));
    endtask

    // ---------------- drivers ----------------
    task automatic cycle(input string tag, input logic s, input logic bf, input logic [31:0] ba,
                         input logic ak, input logic [31:0] rd);
        stall       = s;
        branch_flag = bf;
        branch_addr = ba;
        imem_ack    = ak;
        imem_rdata  = rd;
        @(posedge clk);
        model_step(s, bf, ba, ak, rd);
        #1;
        check_all(tag);
    endtask

    // Called just after a rising edge: reset asserts asynchronously, is
    // checked before the next edge, held across one edge, then released.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b1;
    endtask

    localparam logic [31:0] RD0 = 32'h2001_0005;

    initial begin
        logic s, bf, ak;
        logic [31:0] ba, rd;

        rst         = 1'b0;
        stall       = 1'b0;
        branch_flag = 1'b0;
        branch_addr = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // Sequential fetch: first request one edge after reset release.
        cycle("seq.issue", 0, 0, 0, 0, 0);
        chk("seq.first_req", 32'(imem_req), 32'd1);
        chk("seq.first_addr", imem_addr, 32'h0);
        cycle("seq.ack0", 0, 0, 0, 1, RD0);
        chk("seq.inst_pc0", inst_pc, 32'h0);
        chk("seq.inst0", inst, RD0);
        cycle("seq.gap1", 0, 0, 0, 0, 0);
        cycle("seq.ack1", 0, 0, 0, 1, RD0);
        chk("seq.inst_pc1", inst_pc, 32'h4);
        cycle("seq.gap2", 0, 0, 0, 0, 0);
        cycle("seq.ack2", 0, 0, 0, 1, RD0);
        chk("seq.inst_pc2", inst_pc, 32'h8);
        chk("seq.pc_after3", pc, 32'hC);

        // Ack with stall -> HOLD, then branch while held.
        cycle("hold.enter", 1, 0, 0, 1, 32'h1234_5678);
        chk("hold.req_low", 32'(imem_req), 32'd0);
        cycle("hold.branch", 1, 1, 32'h1111_1111, 0, 0);
        chk("hold.branch_pc", pc, 32'h1111_1110);
        chk("hold.no_valid", 32'(inst_valid), 32'd0);
        cycle("hold.release", 0, 0, 0, 0, 0);
        chk("hold.req_addr", imem_addr, 32'h1111_1110);

        // Branches during an outstanding request: latest target wins.
        cycle("pend.b40", 0, 1, 32'h40, 0, 0);
        cycle("pend.b80", 0, 1, 32'h80, 0, 0);
        cycle("pend.wait", 0, 0, 0, 0, 0);
        cycle("pend.ack", 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("pend.discard", 32'(inst_valid), 32'd0);
        chk("pend.pc", pc, 32'h80);

        // Branch in the same cycle as ack.
        cycle("same.ack", 0, 1, 32'h200, 1, 32'hCAFE_0001);
        chk("same.discard", 32'(inst_valid), 32'd0);
        chk("same.addr", imem_addr, 32'h200);

        // Timeout: no ack for MAX_WAIT request cycles.
        for (int i = 0; i < 14; i++) cycle("tmo.wait", 0, 0, 0, 0, 0);
        chk("tmo.not_yet", 32'(fetch_err), 32'd0);
        cycle("tmo.hit", 0, 0, 0, 0, 0);
        chk("tmo.err", 32'(fetch_err), 32'd1);
        chk("tmo.req_low", 32'(imem_req), 32'd0);
        cycle("tmo.ignore_br", 0, 1, 32'h500, 1, 32'h1);
        chk("tmo.pc_kept", pc, 32'h200);
        chk("tmo.sticky", 32'(fetch_err), 32'd1);
        do_reset("tmo.rst");
        chk("tmo.cleared", 32'(fetch_err), 32'd0);

        // PC wraparound at the top of the address space.
        cycle("wrap.br", 1, 1, 32'hFFFF_FFFF, 0, 0);
        chk("wrap.pc_top", pc, 32'hFFFF_FFFC);
        cycle("wrap.go", 0, 0, 0, 0, 0);
        cycle("wrap.ack", 0, 0, 0, 1, 32'h0BAD_F00D);
        chk("wrap.pc_zero", pc, 32'h0);
        chk("wrap.inst_pc", inst_pc, 32'hFFFF_FFFC);

        // Reset in mid-request drops the request and a pending branch.
        cycle("midrst.pend", 0, 1, 32'h300, 0, 0);
        rst = 1'b0;
        #1;
        chk("midrst.req_low", 32'(imem_req), 32'd0);
        chk("midrst.pc", pc, 32'h0);
        rst = 1'b1;
        do_reset("midrst");
        cycle("midrst.issue", 0, 0, 0, 0, 0);
        cycle("midrst.ack", 0, 0, 0, 1, 32'h7777_0000);
        chk("midrst.not_lost", 32'(inst_valid), 32'd1);
        chk("midrst.pc_step", pc, 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd.rst");
            end else begin
                s  = ($urandom_range(0, 3) == 0);
                bf = ($urandom_range(0, 7) == 0);
                ba = $urandom;
                ak = ($urandom_range(0, 2) != 0);
                rd = $urandom;
                cycle("rnd", s, bf, ba, ak, rd);
            end
        end

        // Long silence to reach the timeout under random history.
        for (int i = 0; i < 20; i++) cycle("rnd.silence", 0, 0, 0, 0, 0);
        chk("rnd.silence_err", 32'(fetch_err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
